// File: rtl/attn_operand_tx.sv
// Operand-pair transmitter: FIFO of (Q,K) byte pairs serialised as two-beat vld/rdy transfers with row tracking.
// Optional macro ATTN_TX_ROWGAP_EN inserts GAP_CYCLES idle cycles after every completed row.
module attn_operand_tx #(
   parameter int DEPTH      = 8,
   parameter int N_FEAT     = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [7:0]  wr_q,
   input  logic [7:0]  wr_k,
   output logic        wr_rdy,
   output logic [7:0]  data_out,
   output logic        vld_out,
   input  logic        rdy_in,
   output logic        busy,
   output logic        row_done,
   output logic [15:0] pair_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
   localparam logic [FW-1:0] FEAT_LAST = FW'(N_FEAT - 1);

   typedef enum logic [2:0] {IDLE, SEND_Q, SEND_K, HOLD, GAP} state_t;

   state_t            state, state_nx;
   logic signed [7:0] mem_q [DEPTH];
   logic signed [7:0] mem_k [DEPTH];
   logic signed [7:0] head_q, head_k;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count, count_nx;
   logic [FW-1:0]     feat;
   logic              push, pop, row_end;

   assign wr_rdy   = (count != FULL);
   assign push     = wr_en && wr_rdy;
   assign pop      = (state == HOLD);
   assign row_end  = pop && (feat == FEAT_LAST);
   assign count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign head_q   = mem_q[rd_ptr];
   assign head_k   = mem_k[rd_ptr];
   assign busy     = (count != '0) || (state != IDLE);
   assign row_done = row_end;

   // Pair storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr] <= $signed(wr_q);
         mem_k[wr_ptr] <= $signed(wr_k);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         feat     <= '0;
         pair_cnt <= '0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            pair_cnt <= pair_cnt + 16'd1;
            feat     <= row_end ? '0 : feat + 1'b1;
         end
      end
   end

`ifdef ATTN_TX_ROWGAP_EN
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   logic [GW-1:0] gap_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gap_cnt <= '0;
      else if (state != GAP)
         gap_cnt <= '0;
      else
         gap_cnt <= gap_cnt + 1'b1;
   end
`endif

   always_comb begin
      state_nx = state;
      data_out = 8'h00;
      vld_out  = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0)
               state_nx = SEND_Q;
         end
         SEND_Q: begin
            data_out = head_q;
            vld_out  = 1'b1;
            if (rdy_in)
               state_nx = SEND_K;
         end
         // Second beat is taken on vld alone, so rdy_in is not consulted here.
         SEND_K: begin
            data_out = head_k;
            vld_out  = 1'b1;
            state_nx = HOLD;
         end
         HOLD: begin
            data_out = head_k;
`ifdef ATTN_TX_ROWGAP_EN
            if (row_end)
               state_nx = GAP;
            else
`endif
               state_nx = (count_nx != '0) ? SEND_Q : IDLE;
         end
`ifdef ATTN_TX_ROWGAP_EN
         GAP: begin
            if (gap_cnt == GAP_LAST)
               state_nx = (count != '0) ? SEND_Q : IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_attn_operand_tx.sv
// Directed self-checking bench for attn_operand_tx (default parameters, either ATTN_TX_ROWGAP_EN setting).
module tb_attn_operand_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_q = 8'h00;
   logic [7:0]  wr_k = 8'h00;
   logic        wr_rdy;
   logic [7:0]  data_out;
   logic        vld_out;
   logic        rdy_in = 1'b1;
   logic        busy;
   logic        row_done;
   logic [15:0] pair_cnt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int sq_cyc [8];

`ifdef ATTN_TX_ROWGAP_EN
   localparam int ROW_STEP = 4;
`else
   localparam int ROW_STEP = 3;
`endif

   attn_operand_tx dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_q(wr_q), .wr_k(wr_k), .wr_rdy(wr_rdy),
      .data_out(data_out), .vld_out(vld_out), .rdy_in(rdy_in), .busy(busy),
      .row_done(row_done), .pair_cnt(pair_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_vld();
      int n = 0;
      while (!vld_out && n < 20) begin
         tick();
         n++;
      end
      chk("wait_vld", {31'd0, vld_out}, 32'd1);
   endtask

   task automatic write_pair(input logic [7:0] q, input logic [7:0] k);
      wr_en = 1'b1;
      wr_q  = q;
      wr_k  = k;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      // asynchronous reset at start
      #3 rst = 1'b1;
      #1;
      chk("rst_vld", {31'd0, vld_out}, 0);
      chk("rst_data", {24'd0, data_out}, 0);
      chk("rst_wr_rdy", {31'd0, wr_rdy}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_pair_cnt", {16'd0, pair_cnt}, 0);
      tick();
      rst = 1'b0;
      tick();

      // single pair
      write_pair(8'h40, 8'h20);
      chk("sp_idle_vld", {31'd0, vld_out}, 0);
      chk("sp_idle_busy", {31'd0, busy}, 1);
      tick();
      chk("sp_q_data", {24'd0, data_out}, 32'h40);
      chk("sp_q_vld", {31'd0, vld_out}, 1);
      tick();
      chk("sp_k_data", {24'd0, data_out}, 32'h20);
      chk("sp_k_vld", {31'd0, vld_out}, 1);
      tick();
      chk("sp_hold_data", {24'd0, data_out}, 32'h20);
      chk("sp_hold_vld", {31'd0, vld_out}, 0);
      tick();
      chk("sp_pair_cnt", {16'd0, pair_cnt}, 1);
      chk("sp_busy", {31'd0, busy}, 0);
      chk("sp_idle_data", {24'd0, data_out}, 0);

      // backpressure on first beat, none on second
      rdy_in = 1'b0;
      write_pair(8'h40, 8'h20);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_q_data", {24'd0, data_out}, 32'h40);
         chk("bp_q_vld", {31'd0, vld_out}, 1);
         tick();
      end
      rdy_in = 1'b1;
      tick();
      chk("bp_k_data", {24'd0, data_out}, 32'h20);
      chk("bp_k_vld", {31'd0, vld_out}, 1);
      rdy_in = 1'b0;
      tick();
      chk("bp_hold_vld", {31'd0, vld_out}, 0);
      tick();
      chk("bp_pair_cnt", {16'd0, pair_cnt}, 2);

      // fill past full while stalled, then drain in order
      for (int i = 1; i <= 9; i++) begin
         chk("full_wr_rdy", {31'd0, wr_rdy}, (i == 9) ? 32'd0 : 32'd1);
         write_pair(8'(i), 8'(i + 16));
      end
      rdy_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         wait_vld();
         chk("drain_q", {24'd0, data_out}, i);
         tick();
         chk("drain_k", {24'd0, data_out}, i + 16);
         tick();
         tick();
      end
      tick();
      chk("drain_pair_cnt", {16'd0, pair_cnt}, 10);
      chk("drain_busy", {31'd0, busy}, 0);

      // reset while the second beat is on the bus with pairs queued
      rdy_in = 1'b0;
      write_pair(8'h31, 8'h41);
      write_pair(8'h32, 8'h42);
      write_pair(8'h33, 8'h43);
      rdy_in = 1'b1;
      tick();
      chk("mid_k_data", {24'd0, data_out}, 32'h41);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_vld", {31'd0, vld_out}, 0);
      chk("mid_rst_data", {24'd0, data_out}, 0);
      chk("mid_rst_wr_rdy", {31'd0, wr_rdy}, 1);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_pair_cnt", {16'd0, pair_cnt}, 0);
      #1 rst = 1'b0;
      tick();
      chk("post_rst_busy", {31'd0, busy}, 0);

      // two rows of four pairs; row_done must follow pairs 4 and 8
      rdy_in = 1'b0;
      for (int i = 0; i < 8; i++)
         write_pair(8'(8'h50 + i), 8'(8'h60 + i));
      rdy_in = 1'b1;
      for (int p = 0; p < 8; p++) begin
         wait_vld();
         sq_cyc[p] = cyc;
         chk("row_q", {24'd0, data_out}, 32'h50 + p);
         tick();
         chk("row_k_done", {31'd0, row_done}, 0);
         tick();
         chk("row_hold_done", {31'd0, row_done}, (p == 3 || p == 7) ? 32'd1 : 32'd0);
         tick();
      end
      chk("row_gap_step", sq_cyc[4] - sq_cyc[3], ROW_STEP);
      chk("row_inner_step", sq_cyc[2] - sq_cyc[1], 3);
      chk("row_pair_cnt", {16'd0, pair_cnt}, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
